load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Initiator side of the data memory interface. It accepts one load/store request at a time
//   from the execute stage and sequences memory reads and writes over a byte-addressed,
//   32-bit little-endian port. It handles byte, halfword and word lanes, sign/zero extension,
//   read-modify-write for sub-word stores, and misalignment detection. Returns done/err.
// PARAMETERS
//   SIZE   12   memory address width in bits; mem_addr = addr[SIZE-1:0] with [1:0] forced to 0
// PORTS
//   clk         in   1     system clock, all state on posedge
//   rst         in   1     asynchronous, active-high reset
//   req         in   1     request valid; sampled only while busy=0
//   we          in   1     1=store, 0=load
//   funct3      in   3     000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
//   addr        in   32    byte address
//   wdata       in   32    store data; the lane is taken from the LSBs
//   rdata       out  32    extended load result, valid while done=1, held afterwards
//   busy        out  1     request in flight (any state other than IDLE)
//   done        out  1     one-cycle completion pulse
//   err         out  1     with done: misaligned or illegal funct3, no memory access made
//   mem_addr    out  SIZE  word-aligned address to data memory
//   mem_dataW   out  32    write data to data memory
//   mem_dataR   in   32    read data from data memory (X while mem_memR=0)
//   mem_memR    out  1     memory read enable
//   mem_memW    out  1     memory write enable (memory writes on posedge clk)
// BEHAVIOUR
//   Reset values: state=IDLE. rdata, mem_addr and mem_dataW are 0. busy, done, err,
//   mem_memR and mem_memW are 0.
//   States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
//   IDLE: on req=1 at a clock edge, latch we, funct3, addr and wdata.
//     - err case: H/HU/SH with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111; store
//       with 100/101. Go to DONE with err=1 and no memory access.
//     - Otherwise: load goes to RD; SW goes to WR; SB/SH go to RMW_RD.
//   RD / RMW_RD: mem_memR=1 for exactly one cycle. mem_dataR is captured at the ending edge.
//     - RD: go to DONE, with rdata = extended lane.
//     - RMW_RD: go to RMW_WR, with the word held in a merge register.
//   Lane select: byte lane = addr[1:0] -> bits [8*k+7:8*k]; halfword lane = addr[1] -> [16*k+15:16*k].
//   Extension: B and H sign-extend from the lane MSB; BU and HU zero-extend; W passes through.
//   WR: mem_memW=1, mem_dataW=wdata for one cycle, then DONE.
//   RMW_WR: mem_memW=1 for one cycle, then DONE.
//     - mem_dataW = captured word with only the target lane replaced by wdata[7:0] or [15:0].
//   DONE: done=1 (and err as latched) for one cycle, then IDLE.
//   Latency from the accept edge to done high:
//     - err: 1 cycle. Load: 2 cycles. SW: 2 cycles. SB/SH: 3 cycles.
//     - Minimum request spacing is therefore 3/3/4 cycles.
//   mem_memR is low in DONE and IDLE, so it always toggles between reads. The memory samples
//   on memR edges; back-to-back reads never hold memR high.
//   mem_memR and mem_memW are never both 1 and are registered (glitch-free).
//   req while busy=1 is ignored, not queued. rdata changes only on successful loads; stores
//   and errors leave it unchanged.
//   addr bits above SIZE-1 are ignored, so accesses wrap within the memory.
//   Reset mid-operation: immediately return to IDLE and drop mem_memW/mem_memR. An
//   interrupted RMW before RMW_WR leaves memory unmodified, and no done pulse is issued.
// TESTING
//   1. SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> memW one cycle; done 2 cycles after
//      each accept; rdata=0xDEADBEEF.
//   2. Word 0x10 = 0x80FF7F01. LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080;
//      LH 0x10 -> 0x00007F01; LHU 0x12 -> 0x000080FF.
//   3. Word 0x20 = 0x11223344. SB 0x21 wdata=0xAA -> read then write; word = 0x1122AA44.
//      Then SH 0x22 wdata=0xBEEF -> 0xBEEFAA44.
//   4. LW 0x02, SH 0x05, funct3=011 -> done+err 1 cycle after accept; mem_memR and
//      mem_memW never assert; rdata unchanged.
//   5. Back-to-back LW 0x0, LW 0x4 with req held high -> mem_memR falls between reads;
//      both rdata values correct; req during busy ignored.
//   6. Assert rst during RMW_RD of SB -> outputs return to reset values asynchronously;
//      target word unchanged; no done pulse.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator handling B/H/W loads and stores with RMW and misalign checks
module load_store_unit #(
    parameter int SIZE = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [SIZE-1:0] mem_addr,
    output logic [31:0]     mem_dataW,
    input  logic [31:0]     mem_dataR,
    output logic            mem_memR,
    output logic            mem_memW
);
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;
    state_t      state, next;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] wd_q;
    logic        accept, bad, addr_unused;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext, merged;

    assign accept      = state == IDLE && req;
    assign busy        = state != IDLE;
    assign addr_unused = ^addr[31:SIZE];
    assign bad = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (we && funct3[2])
              || (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == 3'b010 && addr[1:0] != 2'b00);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // next-state: errors skip memory, SW writes directly, sub-word stores read first
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (req) next = bad ? DONE : !we ? RD : funct3 == 3'b010 ? WR : RMW_RD;
            RD:      next = DONE;
            WR:      next = DONE;
            RMW_RD:  next = RMW_WR;
            RMW_WR:  next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // lane extraction, load extension and sub-word store merge on the read word
    always_comb begin
        lane_b = mem_dataR[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? mem_dataR[31:16] : mem_dataR[15:0];
        ext = f3_q == 3'b000 ? {{24{lane_b[7]}}, lane_b}
            : f3_q == 3'b100 ? {24'b0, lane_b}
            : f3_q == 3'b001 ? {{16{lane_h[15]}}, lane_h}
            : f3_q == 3'b101 ? {16'b0, lane_h}
            : mem_dataR;
        merged = f3_q[0] ? (off_q[1] ? {wd_q, mem_dataR[15:0]} : {mem_dataR[31:16], wd_q})
               : (mem_dataR & ~(32'hFF << {off_q, 3'b000})) | ({24'b0, wd_q[7:0]} << {off_q, 3'b000});
    end

    // registered outputs and request latches; strobes follow the next state so they never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata     <= '0;
            mem_addr  <= '0;
            mem_dataW <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_memR  <= 1'b0;
            mem_memW  <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            wd_q      <= '0;
        end else begin
            done     <= next == DONE;
            err      <= accept && bad;
            mem_memR <= next == RD || next == RMW_RD;
            mem_memW <= next == WR || next == RMW_WR;
            if (accept) begin
                f3_q     <= funct3;
                off_q    <= addr[1:0];
                wd_q     <= wdata[15:0];
                mem_addr <= {addr[SIZE-1:2], 2'b00};
                if (we) mem_dataW <= wdata;
            end
            if (state == RD) rdata <= ext;
            if (state == RMW_RD) mem_dataW <= merged;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
    localparam int SIZE = 12;
    logic            clk, rst, req, we, busy, done, err, mem_memR, mem_memW;
    logic [2:0]      funct3;
    logic [31:0]     addr, wdata, rdata, mem_dataW, mem_dataR;
    logic [SIZE-1:0] mem_addr;
    logic [31:0]     mem     [0:1023];
    logic [31:0]     ref_mem [0:1023];
    logic [31:0]     rdata_ref;
    int              errors = 0, checks = 0;

    load_store_unit #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
        .mem_dataW(mem_dataW), .mem_dataR(mem_dataR), .mem_memR(mem_memR), .mem_memW(mem_memW)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] x = i;
        return (x * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // the memory: preloaded, then written on posedge when memW is high
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_memW) mem[mem_addr[SIZE-1:2]] <= mem_dataW;
        end
    end
    assign mem_dataR = mem_memR ? mem[mem_addr[SIZE-1:2]] : 'x;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input bit w, input logic [2:0] f, input logic [31:0] a);
        int fi = f;
        return fi == 3 || fi >= 6 || (w && fi >= 4) || ((fi == 1 || fi == 5) && a[0]) || (fi == 2 && a[1:0] != 0);
    endfunction

    function automatic int nbytes(input logic [2:0] f);
        return f[1:0] == 0 ? 1 : f[1:0] == 1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f, input int off);
        int n = nbytes(f);
        longint v = (longint'(w) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
        if (!f[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [2:0] f, input int off, input logic [31:0] d);
        logic [31:0] r = w;
        for (int i = 0; i < nbytes(f); i++) r[8 * (off + i) +: 8] = d[8 * i +: 8];
        return r;
    endfunction

    // one request from idle; checks latency, err, strobe counts and rdata against the model
    task automatic txn(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int lat = 0, nr = 0, nw = 0, both = 0, exp_lat, exp_r, exp_w;
        int idx = int'(a[SIZE-1:2]);
        bit e = is_err(w, f, a);
        if (e) begin exp_lat = 1; exp_r = 0; exp_w = 0; end
        else if (!w) begin
            exp_lat = 2; exp_r = 1; exp_w = 0;
            rdata_ref = m_load(ref_mem[idx], f, int'(a[1:0]));
        end else if (f == 3'b010) begin
            exp_lat = 2; exp_r = 0; exp_w = 1;
            ref_mem[idx] = d;
        end else begin
            exp_lat = 3; exp_r = 1; exp_w = 1;
            ref_mem[idx] = m_store(ref_mem[idx], f, int'(a[1:0]), d);
        end
        @(negedge clk);
        req = 1; we = w; funct3 = f; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 0;
        do begin
            @(negedge clk);
            lat++;
            nr += int'(mem_memR);
            nw += int'(mem_memW);
            both += int'(mem_memR & mem_memW);
        end while (!done && lat < 10);
        chk("latency", lat, exp_lat);
        chk("err", err, e);
        chk("rdata", rdata, rdata_ref);
        chk("reads", nr, exp_r);
        chk("writes", nw, exp_w);
        chk("rw_overlap", both, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("back_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int nr, ndone, bad;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        rdata_ref = 0;
        rst = 1; req = 0; we = 0; funct3 = 0; addr = 0; wdata = 0;
        #3;
        chk("rst_rdata", rdata, 0);
        chk("rst_flags", {busy, done, err, mem_memR, mem_memW}, 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_dataW", mem_dataW, 0);
        @(negedge clk) rst = 0;

        txn(1, 3'b010, 32'h10, 32'hDEADBEEF);
        txn(0, 3'b010, 32'h10, 0);
        chk("t1_lw", rdata, 32'hDEADBEEF);

        txn(1, 3'b010, 32'h10, 32'h80FF7F01);
        txn(0, 3'b000, 32'h13, 0); chk("t2_lb", rdata, 32'hFFFFFF80);
        txn(0, 3'b100, 32'h13, 0); chk("t2_lbu", rdata, 32'h00000080);
        txn(0, 3'b001, 32'h10, 0); chk("t2_lh", rdata, 32'h00007F01);
        txn(0, 3'b101, 32'h12, 0); chk("t2_lhu", rdata, 32'h000080FF);

        txn(1, 3'b010, 32'h20, 32'h11223344);
        txn(1, 3'b000, 32'h21, 32'h000000AA); chk("t3_sb", mem[8], 32'h1122AA44);
        txn(1, 3'b001, 32'h22, 32'h0000BEEF); chk("t3_sh", mem[8], 32'hBEEFAA44);

        txn(0, 3'b010, 32'h02, 0);
        txn(1, 3'b001, 32'h05, 32'h1234);
        txn(0, 3'b011, 32'h10, 0);
        chk("t4_rdata", rdata, 32'h000080FF);

        nr = 0; ndone = 0;
        @(negedge clk);
        req = 1; we = 0; funct3 = 3'b010; addr = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) addr = 4;
            if (mem_memR) begin nr++; if (nr == 2) req = 0; end
            if (n == 3) chk("b2b_memr_gap", mem_memR, 0);
            if (done) begin
                ndone++;
                if (ndone == 1) begin chk("b2b_d1_at", n, 2); chk("b2b_rd0", rdata, ref_mem[0]); end
                else begin chk("b2b_d2_at", n, 5); chk("b2b_rd1", rdata, ref_mem[1]); end
            end
        end
        req = 0;
        chk("b2b_reads", nr, 2);
        chk("b2b_dones", ndone, 2);
        rdata_ref = ref_mem[1];

        @(negedge clk);
        req = 1; we = 1; funct3 = 3'b000; addr = 32'h21; wdata = 32'h55;
        @(posedge clk);
        #1 req = 0;
        chk("t6_in_rmw_rd", mem_memR, 1);
        #2 rst = 1;
        #1;
        chk("t6_rst_flags", {busy, done, err, mem_memR, mem_memW}, 0);
        chk("t6_rst_rdata", rdata, 0);
        chk("t6_rst_addr", 32'(mem_addr), 0);
        chk("t6_rst_dataW", mem_dataW, 0);
        @(negedge clk);
        @(negedge clk) rst = 0;
        rdata_ref = 0;
        ndone = 0;
        repeat (4) begin @(negedge clk); ndone += int'(done); end
        chk("t6_no_done", ndone, 0);
        chk("t6_word", mem[8], 32'hBEEFAA44);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a = ($urandom() & 32'hFFFFF000) | $urandom_range(0, 63);
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
        end

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
